// File: rtl/loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states and the handshake bytes.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_SYNC,
        RECV_SIZE,
        RECV_PROG,
        SEND_READY,
        DONE
    } state_t;

    localparam logic [7:0] LD_SYNC_BYTE  = 8'h99;
    localparam logic [7:0] LD_READY_BYTE = 8'hAA;

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; lanes left unwritten read as zero.
module word_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [1:0]  lane,
    input  logic [7:0]  data,
    input  logic        last,
    output logic        complete,
    output logic [31:0] word
);

    logic [31:0] acc;

    // word already contains the incoming byte so it can be captured on the completing cycle
    always_comb begin
        word = acc;
        word[{lane, 3'b000} +: 8] = data;
    end

    assign complete = load && ((lane == 2'd3) || last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (clear || complete)
            acc <= '0;
        else if (load)
            acc <= word;
    end

endmodule

// File: rtl/program_loader.sv
// CPU-side UART boot loader: sync byte out, size and program bytes in, words into imem, ready byte out.
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 14,
    parameter logic [7:0] SYNC_BYTE  = LD_SYNC_BYTE,
    parameter logic [7:0] READY_BYTE = LD_READY_BYTE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_ready,
    input  logic [7:0]            rdata,
    input  logic                  ferr,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            sdata,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err
);

    localparam logic [32:0] MAX_BYTES = 33'(1) << (ADDR_WIDTH + 2);

    state_t              state, state_nxt;
    logic [31:0]         size, byte_cnt;
    logic [1:0]          size_cnt;
    logic [ADDR_WIDTH:0] word_idx;   // MSB set means imem is full

    logic        accept, tx_fire, take_size, take_prog, size_last, prog_last;
    logic [31:0] size_full;
    logic        pk_complete;
    logic [31:0] pk_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SEND_SYNC;
            SEND_SYNC:  if (tx_fire) state_nxt = RECV_SIZE;
            RECV_SIZE:  if (take_size && size_last)
                            state_nxt = (size_full == 32'd0) ? SEND_READY : RECV_PROG;
            RECV_PROG:  if (take_prog && prog_last) state_nxt = SEND_READY;
            SEND_READY: if (tx_fire) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = start && ((state == IDLE) || (state == DONE));
        tx_fire   = ((state == SEND_SYNC) || (state == SEND_READY)) && !tx_busy && !tx_start;
        take_size = rx_ready && (state == RECV_SIZE);
        take_prog = rx_ready && (state == RECV_PROG);
        size_full = {rdata, size[31:8]};
        size_last = (size_cnt == 2'd3);
        prog_last = (byte_cnt == size - 32'd1);
    end

    word_packer u_packer (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .load     (take_prog),
        .lane     (byte_cnt[1:0]),
        .data     (rdata),
        .last     (prog_last),
        .complete (pk_complete),
        .word     (pk_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_start   <= 1'b0;
            sdata      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= '0;
            size       <= '0;
            size_cnt   <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
        end else begin
            tx_start <= tx_fire;
            if (tx_fire)
                sdata <= (state == SEND_SYNC) ? SYNC_BYTE : READY_BYTE;

            imem_we <= pk_complete && !word_idx[ADDR_WIDTH];
            if (pk_complete) begin
                imem_wdata <= pk_word;
                imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                if (!word_idx[ADDR_WIDTH])
                    word_idx <= word_idx + (ADDR_WIDTH+1)'(1);
            end

            if (accept) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                err      <= '0;
                size     <= '0;
                size_cnt <= '0;
                byte_cnt <= '0;
                word_idx <= '0;
            end

            if (take_size) begin
                size     <= size_full;
                size_cnt <= size_cnt + 2'd1;
                if (ferr)
                    err[0] <= 1'b1;
                if (size_last && ({1'b0, size_full} > MAX_BYTES))
                    err[1] <= 1'b1;
            end

            if (take_prog) begin
                byte_cnt <= byte_cnt + 32'd1;
                if (ferr)
                    err[0] <= 1'b1;
            end

            if (tx_fire && (state == SEND_READY)) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Host-side model of the boot protocol driving program_loader, with a UartTx stand-in and imem monitor.
module tb_program_loader;
    import loader_pkg::*;

    localparam int AW   = 3;
    localparam int MAXW = 1 << AW;

    logic          clock, reset, start, rx_ready, ferr, tx_busy;
    logic [7:0]    rdata, sdata;
    logic          tx_start, imem_we, busy, done;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [1:0]    err;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rx_ready   (rx_ready),
        .rdata      (rdata),
        .ferr       (ferr),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .sdata      (sdata),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic        hold_busy = 1'b0;
    logic        busy_model = 1'b0;
    int          busy_cnt = 0;
    logic        prev_tx = 1'b0;

    assign tx_busy = hold_busy | busy_model;

    // UartTx stand-in and imem monitor, sampled away from the active edge
    always @(negedge clock) begin
        if (reset) begin
            busy_cnt   = 0;
            busy_model = 1'b0;
            prev_tx    = 1'b0;
        end else begin
            if (tx_start) begin
                tests++;
                assert (prev_tx === 1'b0) else begin
                    fails++;
                    $error("FAIL tx_start_width observed=1 expected=0");
                end
                tx_q.push_back(sdata);
                busy_cnt = 8;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            busy_model = (busy_cnt > 0);
            prev_tx    = tx_start;
            if (imem_we) begin
                wa_q.push_back(32'(imem_addr));
                wd_q.push_back(imem_wdata);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        rdata    = b;
        ferr     = fe;
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        ferr     = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clock);
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] b);
        int n = 0;
        while (tx_q.size() == 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (tx_q.size() == 0)
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        else
            chk(tag, 64'(tx_q.pop_front()), 64'(b));
    endtask

    task automatic run_prog(input string tag, input logic [7:0] pb[$], input int fe_idx,
                            input bit do_start);
        int          n  = pb.size();
        logic [31:0] sz = 32'(pb.size());
        int          nw, exp_w;
        logic [31:0] ew;
        tx_q.delete();
        wa_q.delete();
        wd_q.delete();
        if (do_start) begin
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        end
        expect_tx({tag, "_sync"}, LD_SYNC_BYTE);
        for (int i = 0; i < 4; i++) send_byte(sz[8*i +: 8], 1'b0);
        for (int i = 0; i < n; i++) send_byte(pb[i], (i == fe_idx));
        expect_tx({tag, "_ready"}, LD_READY_BYTE);
        repeat (2) @(negedge clock);
        nw    = (n + 3) / 4;
        exp_w = (nw < MAXW) ? nw : MAXW;
        chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'(exp_w));
        for (int w = 0; w < exp_w; w++) begin
            ew = '0;
            for (int j = 0; j < 4; j++)
                if (4*w + j < n) ew[8*j +: 8] = pb[4*w + j];
            chk({tag, "_addr"}, 64'(wa_q[w]), 64'(w));
            chk({tag, "_data"}, 64'(wd_q[w]), 64'(ew));
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), {62'd0, (n > MAXW*4), (fe_idx >= 0)});
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        chk({tag, "_sdata"}, 64'(sdata), 64'd0);
        chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pb[$];
        logic [31:0] sz;
        reset = 1'b1; start = 1'b0; rx_ready = 1'b0; rdata = '0; ferr = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        pb = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        run_prog("t1", pb, -1, 1'b1);

        pb = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        run_prog("t2", pb, -1, 1'b1);

        pb = {};
        run_prog("t3_size0", pb, -1, 1'b1);

        // tx_busy held while a stray byte arrives in SEND_SYNC
        hold_busy = 1'b1;
        tx_q.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        send_byte(8'h55, 1'b0);
        repeat (48) @(negedge clock);
        chk("t4_no_tx_while_busy", 64'(tx_q.size()), 64'd0);
        hold_busy = 1'b0;
        pb = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        run_prog("t4", pb, -1, 1'b0);

        pb = {};
        for (int i = 0; i < 8; i++) pb.push_back(8'($urandom));
        run_prog("t5_ferr", pb, 2, 1'b1);

        // reset after 5 of 8 program bytes
        tx_q.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        expect_tx("t6_sync0", LD_SYNC_BYTE);
        sz = 32'd8;
        for (int i = 0; i < 4; i++) send_byte(sz[8*i +: 8], 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b0);
        reset = 1'b1;
        #1;
        check_idle_outputs("t6_reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        pb = {};
        for (int i = 0; i < 8; i++) pb.push_back(8'($urandom));
        run_prog("t6", pb, -1, 1'b1);

        pb = {};
        for (int i = 0; i < MAXW*4 + 4; i++) pb.push_back(8'($urandom));
        run_prog("overflow", pb, -1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            pb = {};
            for (int i = 0; i < int'($urandom_range(1, MAXW*4)); i++)
                pb.push_back(8'($urandom));
            run_prog("rand", pb, -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
